ysyx_22040931_bpu: RTL

Branch prediction unit for the IF stage: a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. It produces `pre_jump`/`pre_branch` for the fetch PC each cycle and is trained by the ID stage's resolved branch outcome (`jumptype`, `mux_pc`, `branch`, `error_pre`). It is the prediction side of the ID-stage misprediction check. It never redirects fetch on its own; the ID stage still raises `error_pre`.

---
 rtl/ysyx_22040931_bpu.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040931_bpu.sv
// ysyx_22040931_bpu -- IF-stage branch prediction unit.
//
// Direct-mapped branch target buffer with a 2-bit saturating direction counter
// per entry. Lookup of the fetch PC is combinational. Training comes from the
// ID stage's resolved outcome and is written at the clock edge that ends the
// cycle in which it is presented. The unit never redirects fetch itself; the
// ID stage still raises error_pre on a misprediction.
//
// Ports:
//   clock, reset        sole clock; synchronous active-low reset
//   if_pc               fetch PC to predict
//   pre_jump            predicted taken
//   pre_branch          predicted target (0 when pre_jump=0)
//   init_busy           table invalidation sweep in progress
//   upd_pc              PC of the instruction resolved in ID
//   upd_jumptype        00 none, 01 B-type, 10 JAL, 11 taken JALR
//   upd_taken           resolved direction
//   upd_target          resolved target
//   upd_error           ID flagged a misprediction
//   id_stall            ID held this cycle; suppresses training
//   perf_total          resolved control transfers seen while training
//   perf_correct        those resolved without a misprediction
//
// Build option: define YSYX_22040931_BPU_PERF_EN to build the two performance
// counters. Without it both perf outputs are constant 0 and no counter flops
// exist.

module ysyx_22040931_bpu #(
  parameter int ENTRIES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] if_pc,
  output logic        pre_jump,
  output logic [63:0] pre_branch,
  output logic        init_busy,
  input  logic [63:0] upd_pc,
  input  logic [1:0]  upd_jumptype,
  input  logic        upd_taken,
  input  logic [63:0] upd_target,
  input  logic        upd_error,
  input  logic        id_stall,
  output logic [31:0] perf_total,
  output logic [31:0] perf_correct
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 64 - IDX - 2;
  localparam logic [IDX-1:0] LAST_IDX = IDX'(ENTRIES - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e              state_q;
  logic [IDX-1:0]      ptr_q;
  logic [ENTRIES-1:0]  valid_q;
  logic [1:0]          ctr_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [63:0]         target_q [ENTRIES];

  // ---------------------------------------------------------------- lookup
  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx     = if_pc[IDX+1:2];
  assign lk_tag     = if_pc[63:IDX+2];
  assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign init_busy  = (state_q == S_INIT);
  assign pre_jump   = lk_hit && ctr_q[lk_idx][1] && !init_busy;
  assign pre_branch = pre_jump ? target_q[lk_idx] : 64'd0;

  // -------------------------------------------------------------- training
  logic             upd_en;
  logic [IDX-1:0]   upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             wr_ctr;     // counter write
  logic             wr_entry;   // (re)allocate: tag + valid
  logic             wr_target;  // target write
  logic [1:0]       ctr_d;

  assign upd_en  = (upd_jumptype != 2'b00) && !id_stall && (state_q == S_RUN);
  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[63:IDX+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // NOTE: every always_comb output gets a default first, so no path through the
  // block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    wr_ctr    = 1'b0;
    wr_entry  = 1'b0;
    wr_target = 1'b0;
    ctr_d     = ctr_q[upd_idx];
    if (upd_en) begin
      if (upd_jumptype[1]) begin
        // JAL / JALR: unconditional, always (re)install as strongly taken.
        wr_ctr    = 1'b1;
        wr_entry  = 1'b1;
        wr_target = 1'b1;
        ctr_d     = 2'b11;
      end else if (upd_hit) begin
        wr_ctr = 1'b1;
        if (upd_taken) begin
          wr_target = 1'b1;
          if (ctr_q[upd_idx] != 2'b11) ctr_d = ctr_q[upd_idx] + 2'b01;
        end else begin
          if (ctr_q[upd_idx] != 2'b00) ctr_d = ctr_q[upd_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        // Miss on a taken branch evicts whatever alias sits in this slot.
        wr_ctr    = 1'b1;
        wr_entry  = 1'b1;
        wr_target = 1'b1;
        ctr_d     = 2'b10;
      end
    end
  end

  // ------------------------------------------------ FSM, valid and counters
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
    end else begin
      unique case (state_q)
        S_INIT: begin
          valid_q[ptr_q] <= 1'b0;
          ctr_q[ptr_q]   <= 2'b00;
          if (ptr_q == LAST_IDX) state_q <= S_RUN;
          else                   ptr_q   <= ptr_q + 1'b1;
        end
        S_RUN: begin
          if (wr_entry) valid_q[upd_idx] <= 1'b1;
          if (wr_ctr)   ctr_q[upd_idx]   <= ctr_d;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  // NOTE: tag and target storage is deliberately not reset; valid gates every
  // use of it, so only valid (and the counters) need a defined reset value.
  always_ff @(posedge clock) begin
    if (wr_entry)  tag_q[upd_idx]    <= upd_tag;
    if (wr_target) target_q[upd_idx] <= upd_target;
  end

  // -------------------------------------------------- performance counters
`ifdef YSYX_22040931_BPU_PERF_EN
  logic [31:0] perf_total_q;
  logic [31:0] perf_correct_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_total_q   <= '0;
      perf_correct_q <= '0;
    end else if (upd_en) begin
      perf_total_q <= perf_total_q + 32'd1;
      if (!upd_error) perf_correct_q <= perf_correct_q + 32'd1;
    end
  end

  assign perf_total   = perf_total_q;
  assign perf_correct = perf_correct_q;

  // Byte-offset PC bits never select anything.
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};
`else
  assign perf_total   = 32'd0;
  assign perf_correct = 32'd0;

  // Byte-offset PC bits never select anything; upd_error only feeds the
  // counters, which are absent in this build.
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_error};
`endif

endmodule
